// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states, lane helpers.
// LSU_MISALIGNED_SPLIT_EN adds the second-access states used for word-crossing accesses.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
`ifdef LSU_MISALIGNED_SPLIT_EN
    , S_REQ2,
    S_WAIT2
`endif
  } lsu_state_e;

  // Byte mask across two adjacent words; the upper nibble is the spill into the next word.
  function automatic logic [7:0] be_span(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] m;
    case (f3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] s;
    s = be_span(f3, off);
    return s[3:0];
  endfunction

  function automatic logic [3:0] be_hi(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] s;
    s = be_span(f3, off);
    return s[7:4];
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// Load data alignment: selects byte/half/word at the byte offset and sign- or zero-extends it.
// i_pair is {next word, this word}; only the low word is meaningful for non-crossing loads.
module load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] i_pair,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  assign w_sh = 32'(i_pair >> {i_off, 3'b000});

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_data = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_W:    o_data = w_sh;
      F3_BU:   o_data = {24'b0, w_sh[7:0]};
      F3_HU:   o_data = {16'b0, w_sh[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: lane steering for stores, extension for loads, req/gnt + rvalid bus.
// Define LSU_MISALIGNED_SPLIT_EN to perform misaligned accesses (split across words) instead of trapping.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        r_state;
  logic              r_req_ready, r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_we;

  logic              w_err;
  logic [31:0]       w_wdata_lo;
  logic [63:0]       w_pair;
  logic [31:0]       w_ldata;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              r_cross;
  logic [31:0]       r_lo, r_wd_hi;
  logic [3:0]        r_be_hi;
  logic [31:0]       w_wd_hi;

  assign w_err  = illegal_f3(req_we, req_funct3);
  assign w_pair = (r_state == S_WAIT2) ? {mem_rdata, r_lo} : {32'b0, mem_rdata};
`else
  assign w_err  = illegal_f3(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign w_pair = {32'b0, mem_rdata};
`endif

  // Aligned stores replicate into every lane; misaligned ones need the true lane shift.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   w_wdata_lo = {4{req_wdata[7:0]}};
      2'b01:   w_wdata_lo = {2{req_wdata[15:0]}};
      default: w_wdata_lo = req_wdata;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    w_wd_hi = '0;
    if (misaligned(req_funct3, req_addr[1:0]))
      {w_wd_hi, w_wdata_lo} = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
`endif
  end

  load_extend u_load_extend (
    .i_pair   (w_pair),
    .i_funct3 (r_f3),
    .i_off    (r_off),
    .o_data   (w_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_f3        <= '0;
      r_off       <= '0;
      r_we        <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_cross     <= 1'b0;
      r_lo        <= '0;
      r_wd_hi     <= '0;
      r_be_hi     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_f3        <= req_funct3;
            r_off       <= req_addr[1:0];
            r_we        <= req_we;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_mem_be    <= be_for(req_funct3, req_addr[1:0]);
              r_mem_wdata <= w_wdata_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
              r_cross     <= crosses(req_funct3, req_addr[1:0]);
              r_be_hi     <= be_hi(req_funct3, req_addr[1:0]);
              r_wd_hi     <= w_wd_hi;
`endif
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (r_cross && r_we) begin
              r_mem_addr  <= r_mem_addr + ADDR_W'(4);
              r_mem_be    <= r_be_hi;
              r_mem_wdata <= r_wd_hi;
              r_state     <= S_REQ2;
            end else
`endif
            begin
              r_mem_req <= 1'b0;
              if (r_we) begin
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end else begin
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (r_cross) begin
              r_lo       <= mem_rdata;
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_mem_addr + ADDR_W'(4);
              r_mem_be   <= r_be_hi;
              r_state    <= S_REQ2;
            end else
`endif
            begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_ldata;
              r_state     <= S_RESP;
            end
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_REQ2: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_WAIT2;
            end
          end
        end
        S_WAIT2: begin
          if (mem_rvalid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_ldata;
            r_state     <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port; expected values are hand-computed constants.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; on return we are in cycle T+1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b1, f3, a, wd);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd1);
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    chk({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
    chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
    tick();
    chk({tag, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    chk({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, ".wait_no_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".wait_no_rsp"}, 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, exp);
    tick();
    chk({tag, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
    issue(we, f3, a, 32'h1234_5678);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".no_mem_req"}, 32'(mem_req), 32'd0);
    tick();
    chk({tag, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".err_clear"}, 32'(rsp_err), 32'd0);
    chk({tag, ".no_mem_req2"}, 32'(mem_req), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    do_store("sb1003", 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh1002", 3'b001, 32'h0000_1002, 32'hFFFF_1234, 32'h0000_1000, 4'b1100, 32'h1234_1234);
    do_store("sb1001", 3'b000, 32'h0000_1001, 32'h0000_003C, 32'h0000_1000, 4'b0010, 32'h3C3C_3C3C);

    do_load("lb2002",  3'b000, 32'h0000_2002, 32'h0000_2000, 4'b0100, 32'h12F4_5678, 32'hFFFF_FFF4);
    do_load("lbu2002", 3'b100, 32'h0000_2002, 32'h0000_2000, 4'b0100, 32'h12F4_5678, 32'h0000_00F4);
    do_load("lh2002",  3'b001, 32'h0000_2002, 32'h0000_2000, 4'b1100, 32'h12F4_5678, 32'h0000_12F4);
    do_load("lhu2000", 3'b101, 32'h0000_2000, 32'h0000_2000, 4'b0011, 32'h12F4_F678, 32'h0000_F678);
    do_load("lh2000",  3'b001, 32'h0000_2000, 32'h0000_2000, 4'b0011, 32'h12F4_F678, 32'hFFFF_F678);
    do_load("lw2000",  3'b010, 32'h0000_2000, 32'h0000_2000, 4'b1111, 32'h12F4_5678, 32'h12F4_5678);

`ifdef LSU_MISALIGNED_SPLIT_EN
    issue(1'b0, 3'b010, 32'h0000_3001, 32'h0);
    chk("lw3001.a1_addr", mem_addr, 32'h0000_3000);
    chk("lw3001.a1_be", 32'(mem_be), 32'h0000_000E);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h4433_2211;
    tick();
    mem_rvalid = 1'b0;
    chk("lw3001.a2_req", 32'(mem_req), 32'd1);
    chk("lw3001.a2_addr", mem_addr, 32'h0000_3004);
    chk("lw3001.a2_be", 32'(mem_be), 32'h0000_0001);
    chk("lw3001.early_rsp", 32'(rsp_valid), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8877_6655;
    tick();
    mem_rvalid = 1'b0;
    chk("lw3001.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw3001.rsp_err", 32'(rsp_err), 32'd0);
    chk("lw3001.rsp_rdata", rsp_rdata, 32'h5544_3322);
    tick();
`else
    do_err("lw3001_mis", 1'b0, 3'b010, 32'h0000_3001);
    do_err("lh2001_mis", 1'b0, 3'b001, 32'h0000_2001);
    do_err("sh1003_mis", 1'b1, 3'b001, 32'h0000_1003);
`endif

    // Grant withheld for three cycles: request must hold steady.
    issue(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      chk("sw4000.stall_req", 32'(mem_req), 32'd1);
      chk("sw4000.stall_addr", mem_addr, 32'h0000_4000);
      chk("sw4000.stall_be", 32'(mem_be), 32'h0000_000F);
      chk("sw4000.stall_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw4000.stall_we", 32'(mem_we), 32'd1);
      chk("sw4000.stall_ready", 32'(req_ready), 32'd0);
      chk("sw4000.stall_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("sw4000.still_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sw4000.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw4000.rsp_err", 32'(rsp_err), 32'd0);
    chk("sw4000.req_drop", 32'(mem_req), 32'd0);
    tick();
    chk("sw4000.ready_back", 32'(req_ready), 32'd1);

    // Reset while waiting for read data.
    issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstwait.in_wait", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #2;
    chk("rstwait.req_ready", 32'(req_ready), 32'd1);
    chk("rstwait.mem_req", 32'(mem_req), 32'd0);
    chk("rstwait.mem_addr", mem_addr, 32'd0);
    chk("rstwait.mem_be", 32'(mem_be), 32'd0);
    chk("rstwait.rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk("stray.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray.rsp_rdata", rsp_rdata, 32'd0);
    chk("stray.req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("stray.rsp_valid2", 32'(rsp_valid), 32'd0);
    do_load("lw5004", 3'b010, 32'h0000_5004, 32'h0000_5004, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);

    do_err("ld_f3_011", 1'b0, 3'b011, 32'h0000_6000);
    do_err("st_f3_100", 1'b1, 3'b100, 32'h0000_6000);
    do_err("ld_f3_111", 1'b0, 3'b111, 32'h0000_6004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
